agc_timer_unit: RTL and testbench



---
 rtl/agc_timer_unit_pkg.sv | 22 ++
 rtl/agc_timer_unit_prescaler.sv | 37 +++
 rtl/agc_timer_unit.sv | 123 ++++++++++++
 tb/tb_agc_timer_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_timer_unit_pkg.sv
// Shared definitions for the TIME1/TIME2 hardware writer: register select, FSM states, count limit.
package agc_timer_unit_pkg;

    typedef enum logic {
        TIME1 = 1'b0,
        TIME2 = 1'b1
    } reg_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_T1 = 2'd1,
        REQ_T2 = 2'd2
    } timer_state_t;

    localparam logic [13:0] TIME_CNT_MAX = 14'h3FFF;

    // 14-bit wrapping increment; bit 14 of a written timer value is always 0.
    function automatic logic [14:0] time_inc(input logic [14:0] q);
        return {1'b0, q[13:0] + 14'd1};
    endfunction

endpackage

// File: rtl/agc_timer_unit_prescaler.sv
// Timer prescaler: counts 0..DIV-1 while enabled and flags the terminal count as a tick.
// Kept generic so further timer cells can reuse it.
module agc_timer_unit_prescaler #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst_l,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign tick = en && (cnt_reg == CNT_LAST);

    always_comb begin
        cnt_next = cnt_reg;
        if (tick) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/agc_timer_unit.sv
// Hardware writer for TIME1/TIME2: queues prescaler ticks and issues increment writes,
// carrying TIME1 overflow into TIME2. Optional overflow pulse under AGC_TIMER_OVF_IRQ_EN.
module agc_timer_unit
    import agc_timer_unit_pkg::*;
#(
    parameter int DIV      = 16,
    parameter int MAX_PEND = 7,
    parameter int PEND_W   = $clog2(MAX_PEND + 1)
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        en,
    input  logic [14:0] time1_q,
    input  logic [14:0] time2_q,
    output logic        wr_req,
    output reg_t        wr_sel,
    output logic [14:0] wr_data,
    input  logic        wr_gnt,
`ifdef AGC_TIMER_OVF_IRQ_EN
    output logic        irq_t2_ovf,
`endif
    output logic        lost_tick
);

    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

    logic              tick;
    logic              t1_xfer;
    timer_state_t      state_reg;
    timer_state_t      state_next;
    logic [PEND_W-1:0] pend_reg;
    logic [PEND_W-1:0] pend_next;
    logic              lost_reg;
    logic              lost_next;

    agc_timer_unit_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_l(rst_l),
        .en   (en),
        .tick (tick)
    );

    assign t1_xfer   = (state_reg == REQ_T1) && wr_gnt;
    assign lost_tick = lost_reg;

    // A tick and a TIME1 grant in the same cycle cancel; only an uncancelled tick can be lost.
    always_comb begin
        pend_next = pend_reg;
        lost_next = lost_reg;
        if (tick && !t1_xfer) begin
            if (pend_reg == PEND_MAX) begin
                lost_next = 1'b1;
            end else begin
                pend_next = pend_reg + PEND_W'(1);
            end
        end else if (t1_xfer && !tick) begin
            pend_next = pend_reg - PEND_W'(1);
        end
    end

    // Outputs depend only on state and the forwarded q values, so a stalled request
    // keeps its target and re-increments whatever software wrote meanwhile.
    always_comb begin
        state_next = state_reg;
        wr_req     = 1'b0;
        wr_sel     = TIME1;
        wr_data    = '0;
        case (state_reg)
            IDLE: begin
                if (pend_reg != '0) begin
                    state_next = REQ_T1;
                end
            end
            REQ_T1: begin
                wr_req  = 1'b1;
                wr_data = time_inc(time1_q);
                if (wr_gnt) begin
                    state_next = (time1_q[13:0] == TIME_CNT_MAX) ? REQ_T2 : IDLE;
                end
            end
            REQ_T2: begin
                wr_req  = 1'b1;
                wr_sel  = TIME2;
                wr_data = time_inc(time2_q);
                if (wr_gnt) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg <= IDLE;
            pend_reg  <= '0;
            lost_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            lost_reg  <= lost_next;
        end
    end

`ifdef AGC_TIMER_OVF_IRQ_EN
    logic irq_reg;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= (state_reg == REQ_T2) && wr_gnt && (time2_q[13:0] == TIME_CNT_MAX);
        end
    end

    assign irq_t2_ovf = irq_reg;
`endif

endmodule

// File: tb/tb_agc_timer_unit.sv
// Self-checking bench for agc_timer_unit (DIV=4, MAX_PEND=7) with a register-file model.
module tb_agc_timer_unit;
    import agc_timer_unit_pkg::*;

    logic        clk;
    logic        rst_l;
    logic        en;
    logic [14:0] time1_q;
    logic [14:0] time2_q;
    logic        wr_req;
    reg_t        wr_sel;
    logic [14:0] wr_data;
    logic        wr_gnt;
    logic        lost_tick;
`ifdef AGC_TIMER_OVF_IRQ_EN
    logic        irq_t2_ovf;
    int          n_irq;
`endif

    agc_timer_unit #(
        .DIV     (4),
        .MAX_PEND(7)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .en        (en),
        .time1_q   (time1_q),
        .time2_q   (time2_q),
        .wr_req    (wr_req),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
`ifdef AGC_TIMER_OVF_IRQ_EN
        .irq_t2_ovf(irq_t2_ovf),
`endif
        .lost_tick (lost_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests;
    int          n_fail;
    int          cycle_n;
    logic [14:0] m_t1;
    logic [14:0] m_t2;
    logic        s_req;
    reg_t        s_sel;
    logic [14:0] s_data;
    logic        s_lost;
    int          wq_cycle[$];
    reg_t        wq_sel[$];
    logic [14:0] wq_data[$];

    typedef struct {
        logic [14:0] t1;
        logic [14:0] t2;
        logic [14:0] d1;
        logic        carry;
        logic [14:0] d2;
        logic        irq;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called just after a negedge with inputs set: sample one cycle, then advance to the next negedge.
    task automatic step();
        logic        xf;
        reg_t        xs;
        logic [14:0] xd;
        #1;
        s_req  = wr_req;
        s_sel  = wr_sel;
        s_data = wr_data;
        s_lost = lost_tick;
`ifdef AGC_TIMER_OVF_IRQ_EN
        if (irq_t2_ovf) n_irq++;
`endif
        xf = wr_req && wr_gnt;
        xs = wr_sel;
        xd = wr_data;
        if (xf) begin
            $display("[TB] cycle %0d write %s data %h", cycle_n, xs.name(), xd);
            wq_cycle.push_back(cycle_n);
            wq_sel.push_back(xs);
            wq_data.push_back(xd);
        end
        @(negedge clk);
        if (xf) begin
            if (xs == TIME1) m_t1 = xd;
            else             m_t2 = xd;
        end
        time1_q = m_t1;
        time2_q = m_t2;
        cycle_n++;
    endtask

    task automatic clear_log();
        wq_cycle.delete();
        wq_sel.delete();
        wq_data.delete();
        cycle_n = 0;
`ifdef AGC_TIMER_OVF_IRQ_EN
        n_irq = 0;
`endif
    endtask

    task automatic do_reset();
        rst_l   = 1'b0;
        en      = 1'b0;
        wr_gnt  = 1'b0;
        time1_q = m_t1;
        time2_q = m_t2;
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        clear_log();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        n_tests = 0;
        n_fail  = 0;
        // {t1, t2, first write data, carry, second write data, irq pulse}
        vecs[0] = '{15'h0000, 15'h0000, 15'h0001, 1'b0, 15'h0000, 1'b0};
        vecs[1] = '{15'h1234, 15'h0000, 15'h1235, 1'b0, 15'h0000, 1'b0};
        vecs[2] = '{15'h4005, 15'h0000, 15'h0006, 1'b0, 15'h0000, 1'b0};
        vecs[3] = '{15'h3FFF, 15'h0005, 15'h0000, 1'b1, 15'h0006, 1'b0};
        vecs[4] = '{15'h7FFF, 15'h4010, 15'h0000, 1'b1, 15'h0011, 1'b0};
        vecs[5] = '{15'h3FFF, 15'h3FFF, 15'h0000, 1'b1, 15'h0000, 1'b1};

        // Reset state
        m_t1 = '0;
        m_t2 = '0;
        rst_l = 1'b0; en = 1'b0; wr_gnt = 1'b1;
        time1_q = '0; time2_q = '0;
        @(negedge clk);
        #1;
        check("reset_wr_req", wr_req, 1'b0);
        check("reset_wr_sel", wr_sel, TIME1);
        check("reset_lost_tick", lost_tick, 1'b0);

        // Basic tick: first write at cycle 5, then every 4 cycles
        do_reset();
        en = 1'b1; wr_gnt = 1'b1;
        while (wq_cycle.size() < 3 && cycle_n < 40) step();
        check("basic_nwrites", wq_cycle.size(), 3);
        if (wq_cycle.size() >= 3) begin
            check("basic_first_cycle", wq_cycle[0], 5);
            check("basic_first_sel", wq_sel[0], TIME1);
            check("basic_first_data", wq_data[0], 15'h0001);
            check("basic_second_cycle", wq_cycle[1], 9);
            check("basic_second_data", wq_data[1], 15'h0002);
            check("basic_third_cycle", wq_cycle[2], 13);
        end

        // Table: a single tick against various TIME1/TIME2 values
        for (int v = 0; v < 6; v++) begin
            m_t1 = vecs[v].t1;
            m_t2 = vecs[v].t2;
            do_reset();
            en = 1'b1; wr_gnt = 1'b1;
            repeat (4) step();
            en = 1'b0;
            repeat (12) step();
            check($sformatf("vec%0d_nwrites", v), wq_cycle.size(), vecs[v].carry ? 2 : 1);
            if (wq_cycle.size() >= 1) begin
                check($sformatf("vec%0d_t1_sel", v), wq_sel[0], TIME1);
                check($sformatf("vec%0d_t1_data", v), wq_data[0], vecs[v].d1);
            end
            if (vecs[v].carry && wq_cycle.size() >= 2) begin
                check($sformatf("vec%0d_t2_sel", v), wq_sel[1], TIME2);
                check($sformatf("vec%0d_t2_data", v), wq_data[1], vecs[v].d2);
                check($sformatf("vec%0d_t2_follow", v), wq_cycle[1] - wq_cycle[0], 1);
            end
            check($sformatf("vec%0d_idle", v), s_req, 1'b0);
`ifdef AGC_TIMER_OVF_IRQ_EN
            check($sformatf("vec%0d_irq_cycles", v), n_irq, vecs[v].irq);
`endif
        end

        // Backpressure: 5 ticks queued under a stall, then drained with en=0
        m_t1 = '0; m_t2 = '0;
        do_reset();
        en = 1'b1; wr_gnt = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 12) begin
                m_t1 = 15'h0100;
                time1_q = m_t1;
            end
            step();
            if (i >= 5 && (!s_req || s_sel != TIME1)) bad++;
            if (i == 12) check("stall_data_tracks_sw_write", s_data, 15'h0101);
        end
        check("stall_req_sel_stable", bad, 0);
        check("stall_no_writes", wq_cycle.size(), 0);
        en = 1'b0; wr_gnt = 1'b1;
        repeat (30) step();
        check("drain_nwrites", wq_cycle.size(), 5);
        bad = 0;
        for (int k = 1; k < wq_cycle.size(); k++) begin
            if (wq_cycle[k] - wq_cycle[k-1] != 2) bad++;
        end
        check("drain_gap", bad, 0);
        check("drain_final_t1", m_t1, 15'h0105);
        check("drain_idle", s_req, 1'b0);
        check("drain_no_lost", s_lost, 1'b0);

        // Saturation: 10 ticks under a stall, 8th tick is lost
        m_t1 = '0; m_t2 = '0;
        do_reset();
        en = 1'b1; wr_gnt = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 31) check("sat_lost_before_8th", s_lost, 1'b0);
            if (i == 32) check("sat_lost_after_8th", s_lost, 1'b1);
        end
        en = 1'b0; wr_gnt = 1'b1;
        repeat (30) step();
        check("sat_drain_nwrites", wq_cycle.size(), 7);
        check("sat_lost_sticky", s_lost, 1'b1);

        // Simultaneous tick and TIME1 grant with pend=2
        m_t1 = '0; m_t2 = '0;
        do_reset();
        en = 1'b1; wr_gnt = 1'b0;
        repeat (11) step();
        wr_gnt = 1'b1;
        step();
        check("simul_write_at_tick", wq_cycle.size(), 1);
        en = 1'b0;
        repeat (20) step();
        check("simul_total_writes", wq_cycle.size(), 3);

        // Asynchronous reset while a request is stalled
        m_t1 = '0; m_t2 = '0;
        do_reset();
        en = 1'b1; wr_gnt = 1'b0;
        repeat (40) step();
        check("rst_pre_req", wr_req, 1'b1);
        check("rst_pre_lost", lost_tick, 1'b1);
        #2;
        rst_l = 1'b0;
        #1;
        check("rst_async_req", wr_req, 1'b0);
        check("rst_async_lost", lost_tick, 1'b0);
        check("rst_async_sel", wr_sel, TIME1);
        @(negedge clk);
        rst_l = 1'b1;
        clear_log();
        en = 1'b1; wr_gnt = 1'b1;
        while (wq_cycle.size() < 1 && cycle_n < 20) step();
        check("rst_restart_nwrites", wq_cycle.size(), 1);
        if (wq_cycle.size() >= 1) check("rst_restart_cycle", wq_cycle[0], 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
